// File: rtl/appro_mul_pkg.sv
// Shared types and helpers for the iterative approximate multiplier.
// Digits are 3 bits wide; k2_approx is the 2x2 kernel with 3*3 mapped to 7.
package appro_mul_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int DIGIT_W = 3;

  function automatic int num_digits(input int width);
    return width / DIGIT_W;
  endfunction

  function automatic logic [3:0] k2_approx(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd3 && y == 2'd3) return 4'd7;
    return {2'b00, x} * {2'b00, y};
  endfunction

endpackage

// File: rtl/appro_tile3x3.sv
// Combinational 3x3 multiplier tile, exact or approximate (never above exact).
// Zero latency; no flow control.
module appro_tile3x3
  import appro_mul_pkg::*;
(
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic       approx,
  output logic [5:0] p
);

  logic [5:0] exact_p;
  logic [5:0] approx_p;

  assign exact_p = {3'b000, x} * {3'b000, y};

  // x*y split as 4*x2*y + 4*y2*x[1:0] + x[1:0]*y[1:0]; only the last term is approximated
  assign approx_p = (x[2] ? {1'b0, y, 2'b00} : 6'd0)
                  + (y[2] ? {2'b00, x[1:0], 2'b00} : 6'd0)
                  + {2'b00, k2_approx(x[1:0], y[1:0])};

  assign p = approx ? approx_p : exact_p;

endmodule

// File: rtl/appro_mul_iter.sv
// Iterative digit-serial approximate multiplier, one B digit per cycle, K-cycle latency.
// Valid/ready on both sides; APPRO_MUL_ERR_EN adds out_err (exact minus approximate).
module appro_mul_iter
  import appro_mul_pkg::*;
#(
  parameter int WIDTH         = 9,
  parameter int APPROX_DIGITS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_mode,
  output logic               busy
`ifdef APPRO_MUL_ERR_EN
  ,
  output logic [2*WIDTH-1:0] out_err
`endif
);

  localparam int K     = num_digits(WIDTH);
  localparam int ACC_W = 2 * WIDTH;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               mode_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   out_p_q;
  logic               out_mode_q, out_valid_q;
  logic [DIGIT_W-1:0] b_dig;
  logic [K-1:0]       tile_approx;
  logic [5:0]         tile_p [K];
  logic [ACC_W-1:0]   row;

  assign b_dig = b_q[DIGIT_W*idx_q +: DIGIT_W];

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    assign tile_approx[gi] = mode_q && ((gi + int'(idx_q)) < APPROX_DIGITS);
    appro_tile3x3 u_tile (
      .x      (a_q[DIGIT_W*gi +: DIGIT_W]),
      .y      (b_dig),
      .approx (tile_approx[gi]),
      .p      (tile_p[gi])
    );
  end

  always_comb begin
    row = '0;
    for (int i = 0; i < K; i++) row = row + (ACC_W'(tile_p[i]) << (DIGIT_W * i));
    acc_d = acc_q + (row << (DIGIT_W * int'(idx_q)));
  end

`ifdef APPRO_MUL_ERR_EN
  logic [5:0]       tile_ex_p [K];
  logic [ACC_W-1:0] row_ex, acc_ex_q, acc_ex_d, out_err_q;

  for (genvar gi = 0; gi < K; gi++) begin : g_row_ex
    appro_tile3x3 u_tile_ex (
      .x      (a_q[DIGIT_W*gi +: DIGIT_W]),
      .y      (b_dig),
      .approx (1'b0),
      .p      (tile_ex_p[gi])
    );
  end

  always_comb begin
    row_ex = '0;
    for (int i = 0; i < K; i++) row_ex = row_ex + (ACC_W'(tile_ex_p[i]) << (DIGIT_W * i));
    acc_ex_d = acc_ex_q + (row_ex << (DIGIT_W * int'(idx_q)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_ex_q  <= '0;
      out_err_q <= '0;
    end else if (state_q == CALC) begin
      acc_ex_q <= acc_ex_d;
      if (idx_q == IDX_W'(K - 1)) out_err_q <= acc_ex_d - acc_d;
    end else if (in_valid && in_ready) begin
      acc_ex_q <= '0;
    end
  end

  assign out_err = out_err_q;
`endif

  // DONE can hand its result off and take new operands on the same edge
  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_p_q     <= '0;
      out_mode_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            mode_q  <= in_mode;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == IDX_W'(K - 1)) begin
            out_p_q     <= acc_d;
            out_mode_q  <= mode_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              a_q     <= in_a;
              b_q     <= in_b;
              mode_q  <= in_mode;
              acc_q   <= '0;
              idx_q   <= '0;
              state_q <= CALC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_mode  = out_mode_q;
  assign busy      = (state_q == CALC);

endmodule
